// File: rtl/note_player_pkg.sv
// note_player_pkg
//   Shared field widths, note/length codes, mid-octave frequencies, FSM state type
//   and the half-period lookup used by the note player.
//   No ports.
package note_player_pkg;

   localparam int OCTAVE_BITS = 2;
   localparam int NOTE_BITS   = 4;
   localparam int LENGTH_BITS = 2;

   // Note codes; 8..15 are played as a rest.
   localparam logic [NOTE_BITS-1:0] NOTE_REST = 4'd0;
   localparam logic [NOTE_BITS-1:0] NOTE_C    = 4'd1;
   localparam logic [NOTE_BITS-1:0] NOTE_D    = 4'd2;
   localparam logic [NOTE_BITS-1:0] NOTE_E    = 4'd3;
   localparam logic [NOTE_BITS-1:0] NOTE_F    = 4'd4;
   localparam logic [NOTE_BITS-1:0] NOTE_G    = 4'd5;
   localparam logic [NOTE_BITS-1:0] NOTE_A    = 4'd6;
   localparam logic [NOTE_BITS-1:0] NOTE_B    = 4'd7;

   // Length codes: duration is a whole note shifted right by the code.
   localparam logic [LENGTH_BITS-1:0] LEN_WHOLE   = 2'd0;
   localparam logic [LENGTH_BITS-1:0] LEN_HALF    = 2'd1;
   localparam logic [LENGTH_BITS-1:0] LEN_QUARTER = 2'd2;
   localparam logic [LENGTH_BITS-1:0] LEN_EIGHTH  = 2'd3;

   // Mid-octave frequencies in Hz.
   localparam int F_C = 262;
   localparam int F_D = 294;
   localparam int F_E = 330;
   localparam int F_F = 349;
   localparam int F_G = 392;
   localparam int F_A = 440;
   localparam int F_B = 494;

   typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP, S_DONE} state_e;

   // Mid-octave half period in clock cycles; 0 marks a rest.
   function automatic int unsigned mid_half_period(input int unsigned clk_hz,
                                                   input logic [NOTE_BITS-1:0] n);
      case (n)
         NOTE_C:  return clk_hz / (2 * F_C);
         NOTE_D:  return clk_hz / (2 * F_D);
         NOTE_E:  return clk_hz / (2 * F_E);
         NOTE_F:  return clk_hz / (2 * F_F);
         NOTE_G:  return clk_hz / (2 * F_G);
         NOTE_A:  return clk_hz / (2 * F_A);
         NOTE_B:  return clk_hz / (2 * F_B);
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/note_player_if.sv
// note_player_if
//   Request/response bundle between the note source (key capture or song
//   sequencer, master side) and the note player (slave side).
//   start/stop/octave/note/length : request from master
//   buzzer/busy/done/cur_note     : status and audio from slave
interface note_player_if;
   import note_player_pkg::*;

   logic                   start;
   logic                   stop;
   logic [OCTAVE_BITS-1:0] octave;
   logic [NOTE_BITS-1:0]   note;
   logic [LENGTH_BITS-1:0] length;
   logic                   buzzer;
   logic                   busy;
   logic                   done;
   logic [NOTE_BITS-1:0]   cur_note;

   modport master (output start, stop, octave, note, length,
                   input  buzzer, busy, done, cur_note);
   modport slave  (input  start, stop, octave, note, length,
                   output buzzer, busy, done, cur_note);
endinterface

// File: rtl/note_player_ms_tick.sv
// note_player_ms_tick
//   Free-running millisecond strobe: tick_o pulses for one cycle every
//   CLK_HZ/1000 cycles. The divider is cleared by reset only.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   tick_o : one-cycle ms pulse
module note_player_ms_tick #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);
   localparam int DIV = CLK_HZ / 1000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(DIV - 1));
   assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/note_player.sv
// note_player
//   Plays one (octave, note, length) request as a square wave on the buzzer,
//   followed by a short silence, then pulses done for one cycle.
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   bus   : note_player_if.slave
//           in : start, stop, octave, note, length
//           out: buzzer, busy, done, cur_note
module note_player
   import note_player_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int BEAT_MS = 500,
   parameter int GAP_MS  = 20
) (
   input  logic          clk_i,
   input  logic          rst_i,
   note_player_if.slave  bus
);
   // Low-octave C has the longest half period; size the period counter for it.
   localparam int HP_MAX = (CLK_HZ / (2 * F_C)) * 2;
   localparam int HPW    = $clog2(HP_MAX + 1);
   localparam int MSW    = $clog2(4 * BEAT_MS + 1);

   logic tick;

   note_player_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick)
   );

   state_e               state_q;
   logic                 buzzer_q, busy_q, done_q;
   logic [NOTE_BITS-1:0] cur_note_q;
   logic [HPW-1:0]       hp_q, per_q, hp_mid, hp_d;
   logic [MSW-1:0]       ms_q, tone_ms_q, tone_ms_d;

   // Request decode: half period after the octave shift, and tone time
   // (note duration minus the trailing silence).
   always_comb begin
      hp_mid = HPW'(mid_half_period(CLK_HZ, bus.note));
      case (bus.octave)
         2'd0:    hp_d = hp_mid << 1;
         2'd1:    hp_d = hp_mid;
         default: hp_d = hp_mid >> 1;
      endcase
      tone_ms_d = MSW'(((4 * BEAT_MS) >> bus.length) - GAP_MS);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         buzzer_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cur_note_q <= '0;
         hp_q       <= '0;
         tone_ms_q  <= '0;
         per_q      <= '0;
         ms_q       <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            // Abort from any state; also blocks a same-cycle start.
            state_q    <= S_IDLE;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            cur_note_q <= '0;
            per_q      <= '0;
            ms_q       <= '0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (bus.start) begin
                     state_q    <= S_TONE;
                     busy_q     <= 1'b1;
                     cur_note_q <= bus.note;
                     hp_q       <= hp_d;
                     tone_ms_q  <= tone_ms_d;
                     buzzer_q   <= 1'b0;
                     per_q      <= '0;
                     ms_q       <= '0;
                  end else begin
                     state_q    <= S_IDLE;
                     busy_q     <= 1'b0;
                     cur_note_q <= '0;
                     buzzer_q   <= 1'b0;
                  end
               end
               S_TONE: begin
                  // hp_q == 0 is a rest: counter and buzzer stay idle.
                  if (hp_q != '0) begin
                     if (per_q == hp_q - HPW'(1)) begin
                        per_q    <= '0;
                        buzzer_q <= ~buzzer_q;
                     end else begin
                        per_q <= per_q + HPW'(1);
                     end
                  end
                  // Entering GAP overrides any toggle on the same cycle.
                  if (tick) begin
                     if (ms_q + MSW'(1) == tone_ms_q) begin
                        state_q  <= S_GAP;
                        ms_q     <= '0;
                        per_q    <= '0;
                        buzzer_q <= 1'b0;
                     end else begin
                        ms_q <= ms_q + MSW'(1);
                     end
                  end
               end
               S_GAP: begin
                  buzzer_q <= 1'b0;
                  per_q    <= '0;
                  if (tick) begin
                     if (ms_q + MSW'(1) == MSW'(GAP_MS)) begin
                        state_q    <= S_DONE;
                        ms_q       <= '0;
                        busy_q     <= 1'b0;
                        cur_note_q <= '0;
                        done_q     <= 1'b1;
                     end else begin
                        ms_q <= ms_q + MSW'(1);
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.buzzer   = buzzer_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.cur_note = cur_note_q;
endmodule
